// File: rtl/console_xbar_pkg.sv
// Shared types for the console crossbar: FSM states, route entries and width helper.
package console_xbar_pkg;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

    // Route selectors are stored at a fixed width so one struct serves every INPUT_COUNT.
    localparam int ROUTE_SEL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        APPLY = 2'd2
    } xbar_state_e;

    typedef struct packed {
        logic [ROUTE_SEL_W-1:0] sel;
        logic                   en;
    } route_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/console_xbar_if.sv
// Source, configuration and routed-output bundle for console_xbar.
interface console_xbar_if #(
    parameter int INPUT_COUNT  = 16,
    parameter int OUTPUT_COUNT = 16
);
    import console_xbar_pkg::*;

    localparam int SEL_W = $clog2(INPUT_COUNT);
    localparam int OUT_W = clog2_min1(OUTPUT_COUNT);

    logic [INPUT_COUNT-1:0]  sources;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [OUT_W-1:0]        cfg_out;
    logic [SEL_W-1:0]        cfg_sel;
    logic                    cfg_en;
    logic                    cfg_err;
    logic                    cfg_commit;
    logic                    commit_done;
    logic                    busy;
    logic [OUTPUT_COUNT-1:0] out;

    modport master (
        output sources, cfg_valid, cfg_out, cfg_sel, cfg_en, cfg_commit,
        input  cfg_ready, cfg_err, commit_done, busy, out
    );

    modport slave (
        input  sources, cfg_valid, cfg_out, cfg_sel, cfg_en, cfg_commit,
        output cfg_ready, cfg_err, commit_done, busy, out
    );

endinterface

// File: rtl/console_xbar_sync2.sv
// Single-bit two-flop synchronizer with a configurable reset level.
module xbar_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/console_xbar.sv
// Registered console-line crossbar with shadow route table and break-before-make commit.
// Define XBAR_SYNC_EN to pass every source through a two-flop synchronizer first.
module console_xbar
    import console_xbar_pkg::*;
#(
    parameter int   INPUT_COUNT  = 16,
    parameter int   OUTPUT_COUNT = 16,
    parameter int   BREAK_CYCLES = 16,
    parameter logic IDLE_LEVEL   = IDLE_LEVEL_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    console_xbar_if.slave bus
);
    localparam int SEL_W = $clog2(INPUT_COUNT);
    localparam int OUT_W = clog2_min1(OUTPUT_COUNT);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BREAK_CYCLES);
    localparam logic [SEL_W:0]   SEL_LAST = (SEL_W+1)'(INPUT_COUNT - 1);
    localparam logic [OUT_W:0]   OUT_LAST = (OUT_W+1)'(OUTPUT_COUNT - 1);

    xbar_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUTPUT_COUNT-1:0] brk_q, brk_d;
    logic [OUTPUT_COUNT-1:0] out_q, out_d;
    logic [OUTPUT_COUNT-1:0] hold;
    route_t                  shadow_q [OUTPUT_COUNT];
    route_t                  shadow_d [OUTPUT_COUNT];
    route_t                  active_q [OUTPUT_COUNT];
    route_t                  active_d [OUTPUT_COUNT];
    route_t                  eff_route [OUTPUT_COUNT];
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic [INPUT_COUNT-1:0]  src;
    logic                    cfg_bad;

`ifdef XBAR_SYNC_EN
    for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_sync
        xbar_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (bus.sources[g]),
            .q   (src[g])
        );
    end
`else
    assign src = bus.sources;
`endif

    assign cfg_bad = ({1'b0, bus.cfg_out} > OUT_LAST) || ({1'b0, bus.cfg_sel} > SEL_LAST);

    // Writes land only in IDLE; a commit compares the post-write shadow against the active table.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        brk_d    = brk_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        shadow_d[bus.cfg_out] = '{sel: ROUTE_SEL_W'(bus.cfg_sel), en: bus.cfg_en};
                    end
                end
                if (bus.cfg_commit) begin
                    for (int i = 0; i < OUTPUT_COUNT; i++) begin
                        brk_d[i] = (shadow_d[i] != active_q[i]);
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ((|brk_d) && (BREAK_CYCLES > 0)) ? BREAK : APPLY;
                end
            end
            BREAK: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                active_d = shadow_q;
                brk_d    = '0;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The APPLY cycle already drives the new table so changed lines idle exactly BREAK_CYCLES.
    always_comb begin
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            eff_route[i] = (state_q == APPLY) ? shadow_q[i] : active_q[i];
            hold[i]      = brk_q[i] & (state_q != APPLY);
            out_d[i]     = (eff_route[i].en & ~hold[i]) ? src[eff_route[i].sel[SEL_W-1:0]]
                                                         : IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            brk_q    <= '0;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            out_q    <= {OUTPUT_COUNT{IDLE_LEVEL}};
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            brk_q    <= brk_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            out_q    <= out_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign bus.cfg_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.cfg_err     = err_q;
    assign bus.commit_done = done_q;
    assign bus.out         = out_q;

endmodule
